delay_gen_multi: RTL and testbench
==================================

Name: delay_gen_multi

Overview:
- NCH-channel programmable event-delay generator; successor to the single-channel sign converter.
- Each channel detects a rising edge on its trigger input and counts a programmable coarse delay in clk cycles.
- It then emits a one-cycle fire pulse together with a held fine-delay tap select. That select drives the external delay-line tap mux for sub-cycle placement.
- The per-channel delay word and mode are written through a shared config port. Status reports busy and sticky overrun per channel.

Parameters:
- NCH, 4, number of independent channels (1..16)
- COARSE_W, 8, coarse delay width in clk cycles
- FINE_W, 5, fine tap select width (2^FINE_W delay-line taps)
- CH_W, 2, width of cfg_ch; must satisfy 2^CH_W >= NCH

Ports:
- clk  in  1  single clock; all logic rising-edge
- rst_n  in  1  asynchronous active-low reset
- ext_sgn  in  NCH  per-channel trigger level, already synchronous to clk
- cfg_wr  in  1  config write strobe, one cycle
- cfg_ch  in  CH_W  target channel of the write
- cfg_data  in  1+COARSE_W+FINE_W  {mode, coarse, fine}
- out_sgn  out  NCH  per-channel one-cycle fire pulse
- fine_sel  out  NCH*FINE_W  per-channel tap select; channel i at bits [i*FINE_W +: FINE_W]
- busy  out  NCH  channel is counting
- ovr  out  NCH  sticky overrun flag
- ovr_clr  in  NCH  per-channel clear of ovr, one-cycle pulse

Behaviour:
- Reset (async assert, sync use after deassert):
  - out_sgn=0, fine_sel=0, busy=0, ovr=0.
  - All config regs = 0 (mode 0, coarse 0, fine 0).
  - Counters = 0; FSMs = IDLE.
  - Edge-detect history regs reset to all 1s, so a trigger held high through reset deassert is NOT an edge.
- Edge detect: trig[i] = ext_sgn[i] & ~ext_d[i]; ext_d registered every cycle.
- Config write:
  - On cfg_wr with cfg_ch < NCH, the cfg_data fields load into that channel's config reg at the next edge.
  - cfg_ch >= NCH: write ignored.
  - A write affects only triggers accepted after it. A write in the same cycle as a trigger: the trigger uses the old value.
- Per-channel FSM, states IDLE, COUNT, FIRE:
  - IDLE: on trig, latch coarse into cnt and fine into fine_pend.
    - coarse==0: go to FIRE.
    - Otherwise: go to COUNT, busy=1.
  - COUNT: cnt decrements each cycle. When cnt==1, go to FIRE.
  - FIRE: out_sgn[i]=1 for exactly this cycle; fine_sel[i] loads fine_pend in the same edge that enters FIRE. Next state IDLE.
  - busy=1 in COUNT and FIRE, 0 in IDLE.
- Latency: a trigger edge sampled at cycle t gives out_sgn high in cycle t+1+coarse only.
  - coarse=0 → t+1; coarse=255 → t+256.
- fine_sel[i] holds its value from entry into FIRE until the next FIRE of that channel. It is never changed by config writes.
- Trigger while busy (COUNT or FIRE):
  - mode=0 (drop): trigger ignored; ovr[i] set; the current delay completes unchanged.
  - mode=1 (restart): treated as a new IDLE acceptance. Reload cnt/fine_pend from the current config; ovr[i] set; no pulse for the aborted event.
  - Restart during FIRE: the pulse in that cycle still occurs.
- ovr[i] is sticky until an ovr_clr[i] pulse. If set and clear occur in the same cycle, set wins.
- Channels are fully independent; simultaneous triggers on all channels are all accepted.
- cnt width is COARSE_W; no wrap is possible because loading only occurs from config.
- Reset asserted mid-COUNT aborts immediately; no pulse is emitted after deassert.

Test Plan:
- Write ch0 {0, 5, 17}; rising edge on ext_sgn[0] at cycle t → out_sgn[0]=1 only in t+6; fine_sel ch0=17 from t+6 onward; busy[0] high t+1..t+6.
- Write ch1 coarse=0, fine=3; edge at t → out_sgn[1] at t+1; busy[1] high only at t+1; fine_sel ch1=3.
- ch2 mode=0, coarse=10; edge at t, second edge at t+4 → single pulse at t+11; ovr[2]=1 from t+5. ovr_clr[2] at t+20 → ovr[2]=0 at t+21.
- ch3 mode=1, coarse=10; edge at t, second edge at t+4 → pulse only at t+15; ovr[3] set. Same-cycle ovr_clr and new overrun → ovr stays 1.
- Hold ext_sgn[0]=1 across rst_n release → no pulse. cfg_ch=5 with NCH=4 → no register changes. Config write coincident with edge → old delay used.
- All four channels triggered in the same cycle with coarse 0, 1, 2, 3 → pulses at t+1, t+2, t+3, t+4. rst_n asserted mid-count → all outputs 0, no later pulse.

Source files
------------

// File: rtl/delay_gen_multi.sv
`default_nettype none
// ============================================================================
//  Module   : delay_gen_multi
//  Purpose  : Multi-channel programmable event-delay generator. Each channel
//             detects a rising edge on its trigger, waits a programmable
//             number of clk cycles (coarse delay), then emits a one-cycle
//             fire pulse. It also presents a held fine-delay tap select for
//             an external delay-line tap mux.
//  Ports    : clk          - single clock, rising edge
//             rst_n        - asynchronous active-low reset
//             i_ext_sgn    - per-channel trigger level (synchronous to clk)
//             i_cfg_wr     - one-cycle config write strobe
//             i_cfg_ch     - channel targeted by the write
//             i_cfg_data   - {mode, coarse, fine}
//             i_ovr_clr    - per-channel one-cycle clear of o_ovr
//             o_out_sgn    - per-channel one-cycle fire pulse
//             o_fine_sel   - per-channel tap select, ch i at [i*FINE_W +: FINE_W]
//             o_busy       - channel is counting or firing
//             o_ovr        - sticky overrun (trigger arrived while busy)
//  Revision : 1.0 - initial release
// ============================================================================
module delay_gen_multi #(
  parameter int NCH      = 4,
  parameter int COARSE_W = 8,
  parameter int FINE_W   = 5,
  parameter int CH_W     = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NCH-1:0]             i_ext_sgn,
  input  logic                       i_cfg_wr,
  input  logic [CH_W-1:0]            i_cfg_ch,
  input  logic [COARSE_W+FINE_W:0]   i_cfg_data,
  input  logic [NCH-1:0]             i_ovr_clr,
  output logic [NCH-1:0]             o_out_sgn,
  output logic [NCH*FINE_W-1:0]      o_fine_sel,
  output logic [NCH-1:0]             o_busy,
  output logic [NCH-1:0]             o_ovr
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_COUNT = 2'd1;
  localparam logic [1:0] S_FIRE  = 2'd2;

  // Field split of the config word
  logic                w_cfg_mode;
  logic [COARSE_W-1:0] w_cfg_coarse;
  logic [FINE_W-1:0]   w_cfg_fine;

  assign w_cfg_mode   = i_cfg_data[COARSE_W+FINE_W];
  assign w_cfg_coarse = i_cfg_data[FINE_W +: COARSE_W];
  assign w_cfg_fine   = i_cfg_data[0 +: FINE_W];

  // History resets to all ones so a trigger already high when reset is
  // released is not mistaken for a rising edge.
  logic [NCH-1:0] r_ext_d;
  logic [NCH-1:0] w_trig;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ext_d <= '1;
    else        r_ext_d <= i_ext_sgn;
  end

  assign w_trig = i_ext_sgn & ~r_ext_d;

  genvar i;
  generate
    for (i = 0; i < NCH; i++) begin : g_ch
      logic                r_mode;
      logic [COARSE_W-1:0] r_coarse;
      logic [FINE_W-1:0]   r_fine;
      logic                w_wr_hit;

      logic [1:0]          r_state;
      logic [1:0]          w_state_nxt;
      logic [COARSE_W-1:0] r_cnt;
      logic [FINE_W-1:0]   r_fine_pend;
      logic [FINE_W-1:0]   r_fine_sel;
      logic                r_ovr;
      logic                w_accept;
      logic                w_overrun;
      logic                w_fire;
      logic                w_busy;

      // Out-of-range channel numbers match no channel and are dropped.
      assign w_wr_hit = i_cfg_wr && (i_cfg_ch == CH_W'(i));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_mode   <= 1'b0;
          r_coarse <= '0;
          r_fine   <= '0;
        end else if (w_wr_hit) begin
          r_mode   <= w_cfg_mode;
          r_coarse <= w_cfg_coarse;
          r_fine   <= w_cfg_fine;
        end
      end

      // Acceptance / overrun decode. A trigger while busy always flags an
      // overrun; in restart mode it is also accepted as a fresh event.
      always_comb begin
        w_accept  = 1'b0;
        w_overrun = 1'b0;
        if (w_trig[i]) begin
          if (r_state == S_IDLE) begin
            w_accept = 1'b1;
          end else begin
            w_overrun = 1'b1;
            w_accept  = r_mode;
          end
        end
      end

      // State register
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
      end

      // Next-state logic
      always_comb begin
        w_state_nxt = r_state;
        if (w_accept) begin
          w_state_nxt = (r_coarse == '0) ? S_FIRE : S_COUNT;
        end else begin
          case (r_state)
            S_IDLE:  w_state_nxt = S_IDLE;
            S_COUNT: if (r_cnt == COARSE_W'(1)) w_state_nxt = S_FIRE;
            S_FIRE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
          endcase
        end
      end

      // Output decode
      always_comb begin
        w_fire = (r_state == S_FIRE);
        w_busy = (r_state != S_IDLE);
      end

      // Counter, pending fine value, held tap select and sticky overrun.
      // The tap select loads on every edge that enters FIRE; an acceptance
      // with coarse==0 goes straight to FIRE, so it takes fine from config.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_cnt       <= '0;
          r_fine_pend <= '0;
          r_fine_sel  <= '0;
          r_ovr       <= 1'b0;
        end else begin
          if (w_accept) begin
            r_cnt       <= r_coarse;
            r_fine_pend <= r_fine;
          end else if (r_state == S_COUNT) begin
            r_cnt <= r_cnt - COARSE_W'(1);
          end

          if (w_state_nxt == S_FIRE) begin
            r_fine_sel <= w_accept ? r_fine : r_fine_pend;
          end

          // Set has priority over a same-cycle clear
          if (w_overrun)         r_ovr <= 1'b1;
          else if (i_ovr_clr[i]) r_ovr <= 1'b0;
        end
      end

      assign o_out_sgn[i]                  = w_fire;
      assign o_busy[i]                     = w_busy;
      assign o_ovr[i]                      = r_ovr;
      assign o_fine_sel[i*FINE_W +: FINE_W] = r_fine_sel;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_delay_gen_multi.sv
`default_nettype none
// ============================================================================
//  Module   : tb_delay_gen_multi
//  Purpose  : Self-checking bench for delay_gen_multi (4 channels, CH_W=3 so
//             an out-of-range channel number can be driven). Expected fire
//             events are queued by the stimulus; a monitor matches every
//             observed pulse against the queue.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_delay_gen_multi;

  localparam int NCH      = 4;
  localparam int COARSE_W = 8;
  localparam int FINE_W   = 5;
  localparam int CH_W     = 3;

  logic                     clk;
  logic                     rst_n;
  logic [NCH-1:0]           i_ext_sgn;
  logic                     i_cfg_wr;
  logic [CH_W-1:0]          i_cfg_ch;
  logic [COARSE_W+FINE_W:0] i_cfg_data;
  logic [NCH-1:0]           i_ovr_clr;
  logic [NCH-1:0]           o_out_sgn;
  logic [NCH*FINE_W-1:0]    o_fine_sel;
  logic [NCH-1:0]           o_busy;
  logic [NCH-1:0]           o_ovr;

  delay_gen_multi #(
    .NCH(NCH), .COARSE_W(COARSE_W), .FINE_W(FINE_W), .CH_W(CH_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_ext_sgn(i_ext_sgn), .i_cfg_wr(i_cfg_wr),
    .i_cfg_ch(i_cfg_ch), .i_cfg_data(i_cfg_data), .i_ovr_clr(i_ovr_clr),
    .o_out_sgn(o_out_sgn), .o_fine_sel(o_fine_sel), .o_busy(o_busy),
    .o_ovr(o_ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int ch;
    int at;
    int fine;
  } exp_t;

  exp_t sbq[$];

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int ch, input int at, input int fine);
    exp_t e;
    e.ch = ch; e.at = at; e.fine = fine;
    sbq.push_back(e);
  endtask

  task automatic cfg(input int ch, input int mode, input int coarse, input int fine);
    i_cfg_wr   = 1'b1;
    i_cfg_ch   = CH_W'(ch);
    i_cfg_data = {mode[0], coarse[COARSE_W-1:0], fine[FINE_W-1:0]};
    tick();
    i_cfg_wr   = 1'b0;
  endtask

  // One-cycle high on the selected triggers (inputs idle low before)
  task automatic edge_on(input logic [NCH-1:0] m);
    i_ext_sgn = m;
    tick();
    i_ext_sgn = '0;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) tick();
  endtask

  // Monitor: every fire pulse must match the oldest queued event of its
  // channel in both cycle and tap select.
  int m_idx;
  always @(negedge clk) begin
    if (rst_n) begin
      for (int c = 0; c < NCH; c++) begin
        if (o_out_sgn[c]) begin
          m_idx = -1;
          foreach (sbq[k]) if (m_idx < 0 && sbq[k].ch == c) m_idx = k;
          if (m_idx < 0) begin
            chk($sformatf("unexpected_pulse_ch%0d", c), 1, 0);
          end else begin
            chk($sformatf("pulse_cycle_ch%0d", c), cyc, sbq[m_idx].at);
            chk($sformatf("pulse_fine_ch%0d", c),
                int'(o_fine_sel[c*FINE_W +: FINE_W]), sbq[m_idx].fine);
            sbq.delete(m_idx);
          end
        end
      end
    end
  end

  int t;

  initial begin
    rst_n      = 1'b0;
    i_ext_sgn  = 4'b0001;   // held high through reset release
    i_cfg_wr   = 1'b0;
    i_cfg_ch   = '0;
    i_cfg_data = '0;
    i_ovr_clr  = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    chk("rst_out_sgn", int'(o_out_sgn), 0);
    chk("rst_fine_sel", int'(o_fine_sel), 0);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_ovr", int'(o_ovr), 0);
    repeat (4) tick();
    chk("held_trig_busy", int'(o_busy), 0);
    i_ext_sgn = '0;
    tick();

    // ch0: coarse 5, fine 17 -> pulse t+6, busy t+1..t+6
    cfg(0, 0, 5, 17);
    t = cyc;
    push(0, t + 6, 17);
    edge_on(4'b0001);
    for (int k = 0; k <= 6; k++) begin
      chk($sformatf("ch0_busy_k%0d", k), int'(o_busy[0]), (k < 6) ? 1 : 0);
      tick();
    end
    chk("ch0_fine_hold", int'(o_fine_sel[0 +: FINE_W]), 17);

    // ch1: coarse 0, fine 3 -> pulse t+1, busy only at t+1
    cfg(1, 0, 0, 3);
    t = cyc;
    push(1, t + 1, 3);
    edge_on(4'b0010);
    chk("ch1_busy_t1", int'(o_busy[1]), 1);
    tick();
    chk("ch1_busy_t2", int'(o_busy[1]), 0);
    chk("ch1_fine_hold", int'(o_fine_sel[1*FINE_W +: FINE_W]), 3);

    // ch2: drop mode, coarse 10, second edge at t+4 -> single pulse t+11
    cfg(2, 0, 10, 9);
    t = cyc;
    push(2, t + 11, 9);
    edge_on(4'b0100);
    wait_until(t + 4);
    edge_on(4'b0100);
    chk("ch2_ovr_set", int'(o_ovr[2]), 1);
    wait_until(t + 20);
    i_ovr_clr = 4'b0100;
    tick();
    i_ovr_clr = '0;
    chk("ch2_ovr_clr", int'(o_ovr[2]), 0);

    // ch3: restart mode, coarse 10; edges at t, t+4, t+8 (t+8 with clear)
    cfg(3, 1, 10, 7);
    t = cyc;
    edge_on(4'b1000);
    wait_until(t + 4);
    edge_on(4'b1000);
    chk("ch3_ovr_set", int'(o_ovr[3]), 1);
    wait_until(t + 8);
    push(3, t + 19, 7);
    i_ovr_clr = 4'b1000;
    edge_on(4'b1000);
    i_ovr_clr = '0;
    chk("ch3_ovr_set_wins", int'(o_ovr[3]), 1);
    wait_until(t + 22);

    // Out-of-range write: no channel changes
    cfg(5, 1, 20, 31);
    t = cyc;
    push(0, t + 6, 17);
    push(1, t + 1, 3);
    edge_on(4'b0011);
    wait_until(t + 8);

    // Write coincident with the edge: old delay used, new one afterwards
    t = cyc;
    push(0, t + 6, 17);
    i_cfg_wr   = 1'b1;
    i_cfg_ch   = 3'd0;
    i_cfg_data = {1'b0, 8'd2, 5'd4};
    i_ext_sgn  = 4'b0001;
    tick();
    i_cfg_wr  = 1'b0;
    i_ext_sgn = '0;
    wait_until(t + 8);
    chk("ch0_fine_before_refire", int'(o_fine_sel[0 +: FINE_W]), 17);
    t = cyc;
    push(0, t + 3, 4);
    edge_on(4'b0001);
    wait_until(t + 5);

    // All channels in one cycle, coarse 0..3
    cfg(0, 0, 0, 1);
    cfg(1, 0, 1, 2);
    cfg(2, 0, 2, 3);
    cfg(3, 0, 3, 4);
    t = cyc;
    push(0, t + 1, 1);
    push(1, t + 2, 2);
    push(2, t + 3, 3);
    push(3, t + 4, 4);
    edge_on(4'b1111);
    wait_until(t + 6);

    // Reset asserted mid-count: everything clears, no later pulse
    cfg(0, 0, 20, 5);
    edge_on(4'b0001);
    repeat (5) tick();
    chk("pre_rst_busy", int'(o_busy[0]), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_sgn", int'(o_out_sgn), 0);
    chk("mid_rst_busy", int'(o_busy), 0);
    chk("mid_rst_ovr", int'(o_ovr), 0);
    chk("mid_rst_fine_sel", int'(o_fine_sel), 0);
    tick();
    rst_n = 1'b1;
    repeat (30) tick();
    chk("post_rst_busy", int'(o_busy), 0);

    chk("sb_leftover", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
